prefetch_ar_arbiter: RTL and testbench
======================================

Name: prefetch_ar_arbiter

Overview:
Arbitrates the single DDR read-address channel between demand reads from the AXI master and prefetch reads generated by the prefetcher. Demand traffic has priority. Prefetch issue is gated by three things: a bandwidth-throttle interval, an outstanding-prefetch limit and the enable input. An anti-starvation counter guarantees prefetch progress under sustained demand. The block sits between the prefetcher core/slave AR port and the m_ar port facing the DDR controller.

Parameters:
ADDR_BITS, 16, AR address width
TID_WIDTH, 8, AR transaction ID width
BURST_LEN_WIDTH, 8, AR burst length width
LOG_QUEUE_SIZE, 3, log2 of prefetch queue depth; outstanding counter is LOG_QUEUE_SIZE+1 bits
PRFETCH_FRQ_WIDTH, 6, throttle counter width
STARVE_WIDTH, 4, starvation counter width

Ports:
clk  in  1  clock
resetN  in  1  asynchronous active-low reset
en  in  1  prefetch enable; demand path unaffected
d_ar_valid/d_ar_ready  in/out  1/1  demand AR handshake
d_ar_addr/d_ar_len/d_ar_id  in  ADDR_BITS/BURST_LEN_WIDTH/TID_WIDTH  demand AR payload
p_ar_valid/p_ar_ready  in/out  1/1  prefetch AR handshake
p_ar_addr/p_ar_len/p_ar_id  in  ADDR_BITS/BURST_LEN_WIDTH/TID_WIDTH  prefetch AR payload
m_ar_valid/m_ar_ready  out/in  1/1  DDR-side AR handshake
m_ar_addr/m_ar_len/m_ar_id  out  ADDR_BITS/BURST_LEN_WIDTH/TID_WIDTH  registered DDR AR payload
pr_retire  in  1  one-cycle pulse: one prefetch burst fully returned (r_last)
crs_prBandwidthThrottle  in  PRFETCH_FRQ_WIDTH  minimum cycles between prefetch grants
crs_prOutstandingLimit  in  LOG_QUEUE_SIZE+1  maximum prefetch bursts in flight; 0 disables prefetch
crs_starveLimit  in  STARVE_WIDTH  consecutive demand grants with prefetch pending before prefetch is forced; 0 disables forcing
pr_outstanding  out  LOG_QUEUE_SIZE+1  prefetch bursts in flight
grant_src  out  1  source of the current m_ar beat: 0 = demand, 1 = prefetch
errorCode  out  2  sticky: bit0 = retire while outstanding==0; bit1 = outstanding overflow

Behaviour:
- Reset values: all outputs 0; state = IDLE; all counters 0; m_ar payload registers 0.
- States:
  - IDLE: m_ar_valid=0. Exactly one of d_ar_ready/p_ar_ready is asserted combinationally, for the winner. Handshake captures the payload and moves to DEMAND or PREFETCH.
  - DEMAND/PREFETCH: m_ar_valid=1 and payload is held stable until m_ar_ready. On acceptance, return to IDLE. Both ready outputs are 0 in these states.
- Timing: 1-cycle latency from the source handshake to m_ar_valid. Maximum throughput is 1 grant per 2 cycles.
- Prefetch eligibility (p_elig): all of p_ar_valid, en, throttle counter==0, and pr_outstanding<crs_prOutstandingLimit.
- Winner selection:
  - If p_elig and starve counter reaches crs_starveLimit (crs_starveLimit≠0), prefetch wins.
  - Else if d_ar_valid, demand wins.
  - Else if p_elig, prefetch wins.
  - Else idle.
- Starve counter:
  - Increments, saturating, on each demand grant while p_ar_valid=1.
  - Clears on prefetch grant, or when p_ar_valid=0.
- Throttle counter: loaded with crs_prBandwidthThrottle on prefetch grant (IDLE handshake); otherwise decrements to 0 and holds.
- Outstanding counter:
  - +1 on m_ar handshake in PREFETCH; −1 on pr_retire.
  - Both in the same cycle: unchanged.
  - Retire at 0: stays 0 and sets errorCode[0].
  - Increment at all-ones: holds and sets errorCode[1].
- en deasserted mid-PREFETCH: the held beat still completes. Deasserting en only blocks new prefetch grants; retires still decrement.
- CRS changes take effect the next cycle. Lowering the limit below the current outstanding count only blocks new prefetch grants.
- Asynchronous reset mid-transfer: m_ar_valid drops immediately, counters and errorCode clear, the in-flight beat is discarded.

Optional Feature:
PR_ARB_STATS_EN: when defined, adds outputs stat_demandGrants and stat_prefetchGrants (16 bits each, saturating). They increment on m_ar handshake by source and reset to 0. When undefined, the ports are absent and no counter logic is built.

Test Plan:
- Reset → all outputs 0. Demand addr 0x0eef, len 0, id 5 in IDLE → d_ar_ready=1 the same cycle; m_ar_valid=1 next cycle with m_ar_addr=0x0eef, m_ar_id=5, grant_src=0.
- m_ar_ready held 0 for 5 cycles with the beat pending → m_ar payload stable, both readies 0; ready=1 → IDLE the next cycle.
- Throttle=4, limit=3, continuous p_ar_valid, m_ar_ready=1, pr_retire=0 → exactly 3 prefetch grants ≥4 cycles apart; pr_outstanding=3, then p_ar_ready stays 0.
- One pr_retire pulse → pr_outstanding=2, a fourth prefetch is granted. pr_retire coincident with a prefetch m_ar handshake → count unchanged.
- Continuous demand + prefetch, crs_starveLimit=2 → grant pattern D,D,P repeating. With crs_starveLimit=0 → prefetch never granted.
- pr_retire with pr_outstanding=0 → errorCode=2'b01, sticky until reset; en=0 → no prefetch grants, demand still passes.

Source files
------------

// File: rtl/prefetch_ar_arbiter.sv
// prefetch_ar_arbiter: shares the DDR read-address channel between demand
// reads (priority) and prefetch reads. Prefetch grants are gated by enable,
// a bandwidth-throttle interval and an outstanding-burst limit. A starvation
// counter forces a prefetch grant after a run of demand grants.
//
// Ports:
//   clk, resetN                 clock, asynchronous active-low reset
//   en                          prefetch enable (demand unaffected)
//   d_ar_*                      demand AR slave port (ready is combinational)
//   p_ar_*                      prefetch AR slave port (ready is combinational)
//   m_ar_*                      registered AR master port toward DDR
//   pr_retire                   pulse: one prefetch burst fully returned
//   crs_*                       throttle interval, outstanding limit, starve limit
//   pr_outstanding              prefetch bursts in flight
//   grant_src                   source of current m_ar beat (0 demand, 1 prefetch)
//   errorCode                   sticky: [0] retire at zero, [1] outstanding overflow
//
// Optional: define PR_ARB_STATS_EN to add saturating 16-bit grant counters
// stat_demandGrants / stat_prefetchGrants.
module prefetch_ar_arbiter #(
   parameter int unsigned ADDR_BITS         = 16,
   parameter int unsigned TID_WIDTH         = 8,
   parameter int unsigned BURST_LEN_WIDTH   = 8,
   parameter int unsigned LOG_QUEUE_SIZE    = 3,
   parameter int unsigned PRFETCH_FRQ_WIDTH = 6,
   parameter int unsigned STARVE_WIDTH      = 4
) (
   input  logic                         clk,
   input  logic                         resetN,
   input  logic                         en,
   input  logic                         d_ar_valid,
   output logic                         d_ar_ready,
   input  logic [ADDR_BITS-1:0]         d_ar_addr,
   input  logic [BURST_LEN_WIDTH-1:0]   d_ar_len,
   input  logic [TID_WIDTH-1:0]         d_ar_id,
   input  logic                         p_ar_valid,
   output logic                         p_ar_ready,
   input  logic [ADDR_BITS-1:0]         p_ar_addr,
   input  logic [BURST_LEN_WIDTH-1:0]   p_ar_len,
   input  logic [TID_WIDTH-1:0]         p_ar_id,
   output logic                         m_ar_valid,
   input  logic                         m_ar_ready,
   output logic [ADDR_BITS-1:0]         m_ar_addr,
   output logic [BURST_LEN_WIDTH-1:0]   m_ar_len,
   output logic [TID_WIDTH-1:0]         m_ar_id,
   input  logic                         pr_retire,
   input  logic [PRFETCH_FRQ_WIDTH-1:0] crs_prBandwidthThrottle,
   input  logic [LOG_QUEUE_SIZE:0]      crs_prOutstandingLimit,
   input  logic [STARVE_WIDTH-1:0]      crs_starveLimit,
   output logic [LOG_QUEUE_SIZE:0]      pr_outstanding,
   output logic                         grant_src,
   output logic [1:0]                   errorCode
`ifdef PR_ARB_STATS_EN
   ,
   output logic [15:0]                  stat_demandGrants,
   output logic [15:0]                  stat_prefetchGrants
`endif
);

   localparam int unsigned OUT_W = LOG_QUEUE_SIZE + 1;

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] DEMAND   = 2'd1;
   localparam logic [1:0] PREFETCH = 2'd2;

   logic [1:0]                   state_q, state_d;
   logic [PRFETCH_FRQ_WIDTH-1:0] thr_q;
   logic [STARVE_WIDTH-1:0]      starve_q;
   logic                         p_elig, force_p, d_win, p_win, pr_issue;

   // Prefetch may compete only when enabled, un-throttled and under its limit.
   assign p_elig  = p_ar_valid & en & (thr_q == '0) &
                    (pr_outstanding < crs_prOutstandingLimit);
   assign force_p = p_elig & (crs_starveLimit != '0) & (starve_q >= crs_starveLimit);

   // A prefetch beat accepted by DDR becomes an outstanding burst.
   assign pr_issue = (state_q == PREFETCH) & m_ar_ready;

   // State register and registered m_ar payload.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q    <= IDLE;
         m_ar_valid <= 1'b0;
         m_ar_addr  <= '0;
         m_ar_len   <= '0;
         m_ar_id    <= '0;
         grant_src  <= 1'b0;
      end else begin
         state_q    <= state_d;
         m_ar_valid <= (state_d != IDLE);
         if (d_win) begin
            m_ar_addr <= d_ar_addr;
            m_ar_len  <= d_ar_len;
            m_ar_id   <= d_ar_id;
            grant_src <= 1'b0;
         end else if (p_win) begin
            m_ar_addr <= p_ar_addr;
            m_ar_len  <= p_ar_len;
            m_ar_id   <= p_ar_id;
            grant_src <= 1'b1;
         end
      end
   end

   // Winner selection in IDLE; hold the beat until DDR accepts it.
   always_comb begin
      state_d    = state_q;
      d_win      = 1'b0;
      p_win      = 1'b0;
      d_ar_ready = 1'b0;
      p_ar_ready = 1'b0;
      case (state_q)
         IDLE: begin
            p_win      = force_p | (~d_ar_valid & p_elig);
            d_win      = ~force_p & d_ar_valid;
            d_ar_ready = d_win;
            p_ar_ready = p_win;
            if (d_win)      state_d = DEMAND;
            else if (p_win) state_d = PREFETCH;
         end
         DEMAND, PREFETCH: begin
            if (m_ar_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Throttle interval: reload on prefetch grant, else count down to zero.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN)            thr_q <= '0;
      else if (p_win)         thr_q <= crs_prBandwidthThrottle;
      else if (thr_q != '0)   thr_q <= thr_q - PRFETCH_FRQ_WIDTH'(1);
   end

   // Demand grants seen while prefetch waits; saturates.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN)                         starve_q <= '0;
      else if (!p_ar_valid || p_win)       starve_q <= '0;
      else if (d_win && starve_q != '1)    starve_q <= starve_q + STARVE_WIDTH'(1);
   end

   // Outstanding prefetch bursts with sticky underflow/overflow flags.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         pr_outstanding <= '0;
         errorCode      <= 2'b00;
      end else begin
         case ({pr_issue, pr_retire})
            2'b10: begin
               if (pr_outstanding == '1) errorCode[1]   <= 1'b1;
               else                      pr_outstanding <= pr_outstanding + OUT_W'(1);
            end
            2'b01: begin
               if (pr_outstanding == '0) errorCode[0]   <= 1'b1;
               else                      pr_outstanding <= pr_outstanding - OUT_W'(1);
            end
            default: ;
         endcase
      end
   end

`ifdef PR_ARB_STATS_EN
   // Saturating accepted-beat counters per source.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         stat_demandGrants   <= 16'd0;
         stat_prefetchGrants <= 16'd0;
      end else if (m_ar_ready) begin
         if (state_q == DEMAND && stat_demandGrants != 16'hFFFF)
            stat_demandGrants <= stat_demandGrants + 16'd1;
         if (state_q == PREFETCH && stat_prefetchGrants != 16'hFFFF)
            stat_prefetchGrants <= stat_prefetchGrants + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_prefetch_ar_arbiter.sv
// Testbench for prefetch_ar_arbiter: directed scenarios plus a randomized
// phase, all compared each cycle against a behavioural model of the rules.
module tb_prefetch_ar_arbiter;

   logic        clk = 1'b0;
   logic        resetN;
   logic        en;
   logic        d_ar_valid, p_ar_valid, m_ar_ready, pr_retire;
   logic [15:0] d_ar_addr, p_ar_addr;
   logic [7:0]  d_ar_len, d_ar_id, p_ar_len, p_ar_id;
   logic [5:0]  crs_prBandwidthThrottle;
   logic [3:0]  crs_prOutstandingLimit;
   logic [3:0]  crs_starveLimit;
   wire         d_ar_ready, p_ar_ready, m_ar_valid, grant_src;
   wire  [15:0] m_ar_addr;
   wire  [7:0]  m_ar_len, m_ar_id;
   wire  [3:0]  pr_outstanding;
   wire  [1:0]  errorCode;
`ifdef PR_ARB_STATS_EN
   wire  [15:0] stat_demandGrants, stat_prefetchGrants;
`endif

   always #5 clk = ~clk;

   prefetch_ar_arbiter dut (
      .clk(clk), .resetN(resetN), .en(en),
      .d_ar_valid(d_ar_valid), .d_ar_ready(d_ar_ready), .d_ar_addr(d_ar_addr),
      .d_ar_len(d_ar_len), .d_ar_id(d_ar_id),
      .p_ar_valid(p_ar_valid), .p_ar_ready(p_ar_ready), .p_ar_addr(p_ar_addr),
      .p_ar_len(p_ar_len), .p_ar_id(p_ar_id),
      .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
      .m_ar_len(m_ar_len), .m_ar_id(m_ar_id),
      .pr_retire(pr_retire),
      .crs_prBandwidthThrottle(crs_prBandwidthThrottle),
      .crs_prOutstandingLimit(crs_prOutstandingLimit),
      .crs_starveLimit(crs_starveLimit),
      .pr_outstanding(pr_outstanding), .grant_src(grant_src), .errorCode(errorCode)
`ifdef PR_ARB_STATS_EN
      , .stat_demandGrants(stat_demandGrants), .stat_prefetchGrants(stat_prefetchGrants)
`endif
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Reference model state: one pending beat plus plain integer counters.
   bit          mv, msrc;
   logic [15:0] maddr;
   logic [7:0]  mlen, mid;
   int          thr, stv, outs;
   logic [1:0]  merr;

   // Grant sources observed at the DUT ready/valid handshakes.
   int dq[$];
   int ptimes[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_clear();
      mv = 0; msrc = 0; maddr = '0; mlen = '0; mid = '0;
      thr = 0; stv = 0; outs = 0; merr = 2'b00;
   endfunction

   // Who the rules say wins this cycle.
   function automatic void model_ready(output bit dw, output bit pw);
      bit elig, frc;
      elig = p_ar_valid && en && thr == 0 && outs < int'(crs_prOutstandingLimit);
      frc  = elig && crs_starveLimit != 0 && stv >= int'(crs_starveLimit);
      dw = 0; pw = 0;
      if (!mv) begin
         if (frc)             pw = 1;
         else if (d_ar_valid) dw = 1;
         else if (elig)       pw = 1;
      end
   endfunction

   function automatic void model_step(input bit dw, input bit pw);
      bit issue;
      issue = mv && msrc && m_ar_ready;
      if (issue && !pr_retire) begin
         if (outs == 15) merr[1] = 1'b1; else outs = outs + 1;
      end else if (!issue && pr_retire) begin
         if (outs == 0) merr[0] = 1'b1; else outs = outs - 1;
      end
      if (pw)           thr = int'(crs_prBandwidthThrottle);
      else if (thr > 0) thr = thr - 1;
      if (!p_ar_valid || pw)  stv = 0;
      else if (dw)            stv = (stv + 1 > 15) ? 15 : stv + 1;
      if (mv) begin
         if (m_ar_ready) mv = 0;
      end else if (dw || pw) begin
         mv = 1; msrc = pw;
         maddr = pw ? p_ar_addr : d_ar_addr;
         mlen  = pw ? p_ar_len  : d_ar_len;
         mid   = pw ? p_ar_id   : d_ar_id;
      end
   endfunction

   // One clock: check at the falling edge, advance the model at the rising edge.
   task automatic cycle();
      bit dw, pw;
      @(negedge clk);
      model_ready(dw, pw);
      chk("d_ar_ready", 32'(d_ar_ready), 32'(dw));
      chk("p_ar_ready", 32'(p_ar_ready), 32'(pw));
      chk("m_ar_valid", 32'(m_ar_valid), 32'(mv));
      chk("m_ar_addr", 32'(m_ar_addr), 32'(maddr));
      chk("m_ar_len", 32'(m_ar_len), 32'(mlen));
      chk("m_ar_id", 32'(m_ar_id), 32'(mid));
      chk("grant_src", 32'(grant_src), 32'(msrc));
      chk("pr_outstanding", 32'(pr_outstanding), 32'(outs));
      chk("errorCode", 32'(errorCode), 32'(merr));
      if (d_ar_valid && d_ar_ready) dq.push_back(0);
      if (p_ar_valid && p_ar_ready) begin
         dq.push_back(1);
         ptimes.push_back(cyc);
      end
      @(posedge clk);
      model_step(dw, pw);
      cyc++;
      #1;
   endtask

   task automatic idle_inputs();
      en = 1'b1; d_ar_valid = 0; p_ar_valid = 0; m_ar_ready = 0; pr_retire = 0;
      d_ar_addr = '0; d_ar_len = '0; d_ar_id = '0;
      p_ar_addr = '0; p_ar_len = '0; p_ar_id = '0;
      crs_prBandwidthThrottle = '0; crs_prOutstandingLimit = 4'd3; crs_starveLimit = '0;
   endtask

   // Reset with outputs checked while held; released just after a rising edge.
   task automatic do_reset();
      idle_inputs();
      resetN = 1'b0;
      model_clear();
      dq.delete(); ptimes.delete();
      @(negedge clk);
      chk("rst m_ar_valid", 32'(m_ar_valid), 0);
      chk("rst m_ar_addr", 32'(m_ar_addr), 0);
      chk("rst m_ar_id", 32'(m_ar_id), 0);
      chk("rst grant_src", 32'(grant_src), 0);
      chk("rst pr_outstanding", 32'(pr_outstanding), 0);
      chk("rst errorCode", 32'(errorCode), 0);
      @(posedge clk);
      #1 resetN = 1'b1;
   endtask

   initial begin
      int pat[6];
      int ones;
      pat = '{0, 0, 1, 0, 0, 1};

      // Reset and first demand beat.
      do_reset();
      d_ar_valid = 1; d_ar_addr = 16'h0eef; d_ar_len = 8'd0; d_ar_id = 8'd5;
      #1;
      chk("B same-cycle d_ar_ready", 32'(d_ar_ready), 1);
      cycle();
      chk("B m_ar_valid", 32'(m_ar_valid), 1);
      chk("B m_ar_addr", 32'(m_ar_addr), 32'h0eef);
      chk("B m_ar_id", 32'(m_ar_id), 5);
      chk("B grant_src", 32'(grant_src), 0);

      // Back-pressure: payload stable, no readies even with both sources valid.
      d_ar_addr = 16'h1234; d_ar_id = 8'd9; p_ar_valid = 1; p_ar_addr = 16'h5555;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("B hold addr", 32'(m_ar_addr), 32'h0eef);
         chk("B hold d_ready", 32'(d_ar_ready), 0);
         chk("B hold p_ready", 32'(p_ar_ready), 0);
      end
      m_ar_ready = 1; d_ar_valid = 0; p_ar_valid = 0;
      cycle();
      chk("B back to idle", 32'(m_ar_valid), 0);

      // Throttle and outstanding limit.
      do_reset();
      crs_prBandwidthThrottle = 6'd4; crs_prOutstandingLimit = 4'd3;
      p_ar_valid = 1; m_ar_ready = 1; p_ar_addr = 16'h0a00; p_ar_id = 8'd7;
      for (int i = 0; i < 40; i++) cycle();
      chk("C prefetch grants", 32'(ptimes.size()), 3);
      for (int i = 1; i < ptimes.size(); i++)
         chk("C gap>=4", 32'(ptimes[i] - ptimes[i-1] >= 4), 1);
      chk("C outstanding", 32'(pr_outstanding), 3);
      chk("C p_ready blocked", 32'(p_ar_ready), 0);

      // Retire frees a slot; retire coincident with a prefetch issue.
      pr_retire = 1;
      cycle();
      pr_retire = 0;
      chk("D after retire", 32'(pr_outstanding), 2);
      for (int i = 0; i < 10 && ptimes.size() < 4; i++) cycle();
      chk("D fourth grant", 32'(ptimes.size()), 4);
      pr_retire = 1;
      cycle();
      pr_retire = 0;
      chk("D retire+issue", 32'(pr_outstanding), 2);
      chk("D no error", 32'(errorCode), 0);

      // Starvation forcing: D,D,P pattern, then never with limit 0.
      do_reset();
      crs_starveLimit = 4'd2; crs_prOutstandingLimit = 4'd15;
      d_ar_valid = 1; p_ar_valid = 1; m_ar_ready = 1;
      for (int i = 0; i < 12; i++) cycle();
      chk("E grant count", 32'(dq.size()), 6);
      if (dq.size() >= 6)
         for (int i = 0; i < 6; i++) chk("E pattern", 32'(dq[i]), 32'(pat[i]));
      crs_starveLimit = 4'd0;
      dq.delete();
      for (int i = 0; i < 20; i++) cycle();
      ones = 0;
      foreach (dq[i]) ones += dq[i];
      chk("E no prefetch", 32'(ones), 0);
      chk("E demand grants", 32'(dq.size()), 10);

      // Retire at zero sets sticky error; en=0 blocks prefetch only.
      do_reset();
      pr_retire = 1;
      cycle();
      pr_retire = 0;
      chk("F errorCode", 32'(errorCode), 1);
      for (int i = 0; i < 4; i++) cycle();
      chk("F sticky", 32'(errorCode), 1);
      en = 0; d_ar_valid = 1; p_ar_valid = 1; m_ar_ready = 1;
      dq.delete();
      for (int i = 0; i < 10; i++) cycle();
      ones = 0;
      foreach (dq[i]) ones += dq[i];
      chk("F en=0 demand grants", 32'(dq.size()), 5);
      chk("F en=0 no prefetch", 32'(ones), 0);
      d_ar_valid = 0;
      dq.delete();
      for (int i = 0; i < 6; i++) cycle();
      chk("F en=0 idle", 32'(dq.size()), 0);

      // Randomized traffic against the model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if (i % 50 == 0) begin
            crs_prBandwidthThrottle = 6'($urandom_range(0, 7));
            crs_prOutstandingLimit  = 4'($urandom_range(0, 15));
            crs_starveLimit         = 4'($urandom_range(0, 5));
         end
         en         = ($urandom_range(0, 7) != 0);
         d_ar_valid = 1'($urandom_range(0, 1));
         p_ar_valid = ($urandom_range(0, 3) != 0);
         m_ar_ready = ($urandom_range(0, 9) < 7);
         pr_retire  = ($urandom_range(0, 3) == 0);
         d_ar_addr  = 16'($urandom); d_ar_len = 8'($urandom); d_ar_id = 8'($urandom);
         p_ar_addr  = 16'($urandom); p_ar_len = 8'($urandom); p_ar_id = 8'($urandom);
         cycle();
      end

      // Asynchronous reset while a beat is pending.
      do_reset();
      d_ar_valid = 1; d_ar_addr = 16'hbeef; m_ar_ready = 0;
      cycle();
      chk("H pending", 32'(m_ar_valid), 1);
      #2 resetN = 1'b0;
      #1;
      chk("H async valid", 32'(m_ar_valid), 0);
      chk("H async addr", 32'(m_ar_addr), 0);
      chk("H async outstanding", 32'(pr_outstanding), 0);
      chk("H async error", 32'(errorCode), 0);
      @(posedge clk);
      #1;
      idle_inputs();
      model_clear();
      resetN = 1'b1;
      for (int i = 0; i < 3; i++) cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
